// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares the single MCU SPI link between two bit-serial
// SPI engines (0 = RTC command engine, 1 = generic SPI engine).
// Round-robin grant, pin mux from the registered grant, and a minimum
// chip-select-high gap between owners.
// Optional grant watchdog: define SPI_ARB_TIMEOUT_EN to enable it.
module spi_bus_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic [1:0] Req,
  output logic [1:0] Grant,
  input  logic [1:0] nSelIn,
  input  logic [1:0] DoIn,
  input  logic [1:0] ClkRunningIn,
  input  logic [1:0] ClkStretchIn,
  output logic [1:0] DiOut,
  input  logic       SPIDi,
  output logic       SPIDo,
  output logic       nMCUSel,
  output logic       SPIClkEn,
  output logic [1:0] Owner,
  output logic       TimeoutFlag,
  input  logic       TimeoutClr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int             GW       = 4;
  localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_nxt;
  logic [1:0]    grant_q, grant_nxt;
  logic          last_q, last_nxt;
  logic [GW-1:0] gap_q, gap_nxt;
  logic [1:0]    req_eff;
  logic          g_idx;
  logic          release_hit;
  logic          timeout_hit;
  logic          pick;

  assign g_idx       = grant_q[1];
  // The owner is done only once it has both dropped Req and raised its chip-select.
  assign release_hit = (state_q == BUSY) && !Req[g_idx] && nSelIn[g_idx];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;
  logic [1:0]    blocked_q;
  logic          flag_q;

  assign timeout_hit = (state_q == BUSY) && (to_cnt_q == TO_LAST);
  // A requester that timed out stays masked until it has let go of Req.
  assign req_eff     = Req & ~blocked_q;
  assign TimeoutFlag = flag_q;

  // Watchdog: count cycles spent BUSY, remember who timed out, sticky flag.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      to_cnt_q  <= '0;
      blocked_q <= 2'b00;
      flag_q    <= 1'b0;
    end else begin
      if (state_q == BUSY && state_nxt == BUSY) to_cnt_q <= to_cnt_q + TW'(1);
      else                                     to_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (timeout_hit && grant_q[i]) blocked_q[i] <= 1'b1;
        else if (!Req[i])              blocked_q[i] <= 1'b0;
      end
      // A new timeout wins over a simultaneous clear.
      if (timeout_hit)     flag_q <= 1'b1;
      else if (TimeoutClr) flag_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_timeout_clr;

  assign unused_timeout_clr = TimeoutClr;
  assign timeout_hit        = 1'b0;
  assign req_eff            = Req;
  assign TimeoutFlag        = 1'b0;
`endif

  // State, grant, round-robin pointer and gap counter registers.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;   // requester 0 wins the first tie
      gap_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      gap_q   <= gap_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch for release in BUSY, count out GAP.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state_q;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    gap_nxt   = gap_q;
    pick      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_eff) begin
          pick      = (&req_eff) ? ~last_q : req_eff[1];
          grant_nxt = pick ? 2'b10 : 2'b01;
          last_nxt  = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (release_hit || timeout_hit) begin
          grant_nxt = 2'b00;
          gap_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_nxt = IDLE;
        else             gap_nxt   = gap_q - GW'(1);
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Pin mux driven from the registered grant; idle bus levels with no owner.
  always_comb begin
    nMCUSel  = 1'b1;
    SPIDo    = 1'b1;
    SPIClkEn = 1'b0;
    if (|grant_q) begin
      nMCUSel  = nSelIn[g_idx];
      SPIDo    = DoIn[g_idx];
      SPIClkEn = ClkRunningIn[g_idx] & ~ClkStretchIn[g_idx] & ~nSelIn[g_idx];
    end
  end

  // Only the owner hears MISO; the other requester reads a constant 1.
  assign DiOut = ~grant_q | {2{SPIDi}};
  assign Grant = grant_q;
  assign Owner = {|grant_q, grant_q[1]};

  a_grant_onehot0: assert property (@(posedge SClk) disable iff (Reset) $onehot0(Grant));

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenarios with literal expectations, then a
// randomized phase; a timestamp-based model predicts every output each cycle.
// The watchdog scenario is compiled in when SPI_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

  localparam int GAP  = 2;
  localparam int TOUT = 16;

  logic       SClk = 1'b0;
  logic       Reset;
  logic [1:0] Req, Grant, nSelIn, DoIn, ClkRunningIn, ClkStretchIn, DiOut, Owner;
  logic       SPIDi, SPIDo, nMCUSel, SPIClkEn, TimeoutFlag, TimeoutClr;

  int n_cmp = 0;
  int n_bad = 0;

  spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)) dut (
    .SClk(SClk), .Reset(Reset), .Req(Req), .Grant(Grant), .nSelIn(nSelIn),
    .DoIn(DoIn), .ClkRunningIn(ClkRunningIn), .ClkStretchIn(ClkStretchIn),
    .DiOut(DiOut), .SPIDi(SPIDi), .SPIDo(SPIDo), .nMCUSel(nMCUSel),
    .SPIClkEn(SPIClkEn), .Owner(Owner), .TimeoutFlag(TimeoutFlag),
    .TimeoutClr(TimeoutClr)
  );

  always #5 SClk = ~SClk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner index (-1 = none), edge count, earliest edge a new grant may be
  // issued, edge the current grant was issued on, masked requesters.
  int         m_n = 0, m_own = -1, m_last = 1, m_elig = 0, m_start = 0, m_pick;
  logic [1:0] m_blk = 2'b00, m_nblk, m_avail;
  logic       m_flag = 1'b0, m_to, m_rel;

  always @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      m_n = 0; m_own = -1; m_last = 1; m_elig = 0; m_blk = 2'b00; m_flag = 1'b0;
    end else begin
      m_n++;
      m_to  = 1'b0;
      m_rel = 1'b0;
      if (m_own >= 0) begin
        m_rel = !Req[m_own] && nSelIn[m_own];
`ifdef SPI_ARB_TIMEOUT_EN
        m_to = (m_n - m_start) == TOUT;
`endif
      end
      m_nblk = m_blk;
      for (int i = 0; i < 2; i++) if (!Req[i]) m_nblk[i] = 1'b0;
      if (m_to) m_nblk[m_own] = 1'b1;
      if (m_to) m_flag = 1'b1;
      else if (TimeoutClr) m_flag = 1'b0;
      if (m_rel || m_to) begin
        m_own  = -1;
        m_elig = m_n + GAP + 1;
      end else if (m_own < 0 && m_n >= m_elig) begin
        m_avail = Req & ~m_blk;
        if (m_avail == 2'b11)      m_pick = 1 - m_last;
        else if (m_avail == 2'b01) m_pick = 0;
        else if (m_avail == 2'b10) m_pick = 1;
        else                       m_pick = -1;
        if (m_pick >= 0) begin
          m_own = m_pick; m_last = m_pick; m_start = m_n;
        end
      end
      m_blk = m_nblk;
    end
  end

  // Compare every output against the model once per cycle, away from the edge.
  logic [1:0] e_grant, e_di;
  logic       e_sel, e_do, e_en;
  always @(negedge SClk) begin
    e_grant = 2'b00; e_sel = 1'b1; e_do = 1'b1; e_en = 1'b0; e_di = 2'b11;
    if (m_own >= 0) begin
      e_grant        = (m_own == 0) ? 2'b01 : 2'b10;
      e_sel          = nSelIn[m_own];
      e_do           = DoIn[m_own];
      e_en           = ClkRunningIn[m_own] & ~ClkStretchIn[m_own] & ~nSelIn[m_own];
      e_di[m_own]    = SPIDi;
    end
    check("model_grant", Grant, e_grant);
    check("model_nsel", {1'b0, nMCUSel}, {1'b0, e_sel});
    check("model_do", {1'b0, SPIDo}, {1'b0, e_do});
    check("model_clken", {1'b0, SPIClkEn}, {1'b0, e_en});
    check("model_di", DiOut, e_di);
    check("model_owner", Owner, {m_own >= 0, m_own == 1});
    check("model_tflag", {1'b0, TimeoutFlag}, {1'b0, m_flag});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge SClk);
    #1;
  endtask

  task automatic idle_bus();
    Req = 2'b00; nSelIn = 2'b11; DoIn = 2'b11;
    ClkRunningIn = 2'b00; ClkStretchIn = 2'b00; TimeoutClr = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_grant"}, Grant, 2'b00);
    check({tag, "_nsel"}, {1'b0, nMCUSel}, 2'b01);
    check({tag, "_do"}, {1'b0, SPIDo}, 2'b01);
    check({tag, "_clken"}, {1'b0, SPIClkEn}, 2'b00);
    check({tag, "_owner"}, Owner, 2'b00);
    check({tag, "_di"}, DiOut, 2'b11);
  endtask

  logic b;

  initial begin
    Reset = 1'b1; SPIDi = 1'b0;
    idle_bus();
    repeat (3) tick();
    check_reset_pins("rst");
    check("rst_tflag", {1'b0, TimeoutFlag}, 2'b00);
    Reset = 1'b0;
    tick();

    // Single request: one-cycle latency, pin mux, stretch gating.
    Req = 2'b01;
    #1 check("lat_before", Grant, 2'b00);
    tick();
    check("lat_grant", Grant, 2'b01);
    check("lat_owner", Owner, 2'b10);
    nSelIn = 2'b10; DoIn = 2'b01; ClkRunningIn = 2'b01;
    #1;
    check("mux_nsel", {1'b0, nMCUSel}, 2'b00);
    check("mux_do", {1'b0, SPIDo}, 2'b01);
    check("mux_clken", {1'b0, SPIClkEn}, 2'b01);
    check("mux_di", DiOut, 2'b10);
    ClkStretchIn = 2'b01;
    #1 check("mux_stretch", {1'b0, SPIClkEn}, 2'b00);
    idle_bus();
    tick();
    check("rel_single", Grant, 2'b00);

    // Tie after reset, gap length, round robin.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Req = 2'b11;
    tick();
    check("tie_grant", Grant, 2'b01);
    nSelIn = 2'b10;
    repeat (2) tick();
    Req = 2'b10; nSelIn = 2'b11;
    tick();
    check("gap0_grant", Grant, 2'b00);
    for (int i = 1; i <= GAP; i++) begin
      tick();
      check("gap_grant", Grant, 2'b00);
      check("gap_nsel", {1'b0, nMCUSel}, 2'b01);
    end
    tick();
    check("gap_next", Grant, 2'b10);
    nSelIn = 2'b01;
    tick();
    Req = 2'b01; nSelIn = 2'b11;
    tick();
    check("rr_rel1", Grant, 2'b00);
    Req = 2'b11;
    repeat (GAP) tick();
    check("rr_wait", Grant, 2'b00);
    tick();
    check("rr_grant0", Grant, 2'b01);

    // Requester 1 drops Req with chip-select still low: grant held.
    Req = 2'b10;
    tick();
    check("rr_rel0", Grant, 2'b00);
    repeat (GAP + 1) tick();
    check("hold_grant1", Grant, 2'b10);
    nSelIn = 2'b01;
    tick();
    Req = 2'b00;
    tick();
    check("hold_req_low", Grant, 2'b10);
    tick();
    check("hold_req_low2", Grant, 2'b10);
    nSelIn = 2'b11;
    #1 check("hold_nsel_up", Grant, 2'b10);
    tick();
    check("hold_release", Grant, 2'b00);
    repeat (GAP + 1) tick();

    // Non-granted requester activity must not reach the pins.
    Req = 2'b01;
    tick();
    check("iso_grant", Grant, 2'b01);
    nSelIn = 2'b10; DoIn = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      b = i[0];
      nSelIn[1] = b; DoIn[1] = ~b; SPIDi = b;
      #1;
      check("iso_nsel", {1'b0, nMCUSel}, 2'b00);
      check("iso_do", {1'b0, SPIDo}, 2'b00);
      check("iso_di", DiOut, {1'b1, b});
    end
    idle_bus();
    tick();
    repeat (GAP + 1) tick();

    // Asynchronous reset in the middle of a requester-1 transfer.
    Req = 2'b10;
    tick();
    check("arst_grant1", Grant, 2'b10);
    nSelIn = 2'b01; DoIn = 2'b01; ClkRunningIn = 2'b10;
    #1;
    check("arst_pre_nsel", {1'b0, nMCUSel}, 2'b00);
    check("arst_pre_clken", {1'b0, SPIClkEn}, 2'b01);
    Reset = 1'b1;
    #1 check_reset_pins("arst");
    tick();
    idle_bus();
    Reset = 1'b0;
    Req = 2'b11;
    tick();
    check("arst_after", Grant, 2'b01);
    idle_bus();
    tick();
    repeat (GAP + 1) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // Grant held too long is revoked; requester masked until Req falls.
    Req = 2'b01; nSelIn = 2'b10;
    tick();
    check("to_grant", Grant, 2'b01);
    for (int i = 1; i < TOUT; i++) begin
      tick();
      check("to_held", Grant, 2'b01);
    end
    check("to_flag_pre", {1'b0, TimeoutFlag}, 2'b00);
    tick();
    check("to_revoked", Grant, 2'b00);
    check("to_flag", {1'b0, TimeoutFlag}, 2'b01);
    repeat (TOUT + 4) tick();
    check("to_masked", Grant, 2'b00);
    Req = 2'b00; nSelIn = 2'b11;
    tick();
    TimeoutClr = 1'b1;
    tick();
    TimeoutClr = 1'b0;
    check("to_clear", {1'b0, TimeoutFlag}, 2'b00);
    Req = 2'b01;
    tick();
    check("to_regrant", Grant, 2'b01);
    idle_bus();
    tick();
    repeat (GAP + 1) tick();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      Reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) Req[i] = ~Req[i];
        if ($urandom_range(0, 3) == 0) nSelIn[i] = ~nSelIn[i];
      end
      DoIn         = 2'($urandom);
      ClkRunningIn = 2'($urandom);
      ClkStretchIn = 2'($urandom);
      SPIDi        = 1'($urandom);
      TimeoutClr   = ($urandom_range(0, 15) == 0);
    end
    Reset = 1'b0;
    idle_bus();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
